// File: rtl/kd_tree_controller_pkg.sv
// rtl/kd_tree_controller_pkg.sv - shared types and default widths for the kd-tree controller
// Purpose: FSM state encoding plus default sizing used by the controller, its FIFO and bus interface.
// Ports: none (package).
package kd_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SEARCH = 2'd2
  } state_t;

  localparam int PATCH_WIDTH   = 55;
  localparam int ADDRESS_WIDTH = 8;
  localparam int DSIZE         = 11;
  localparam int NUM_NODES     = 63;

endpackage

// File: rtl/kd_tree_controller_if.sv
// rtl/kd_tree_controller_if.sv - query patch and leaf result handshake bundle
// Purpose: groups the patch (in) and leaf (out) valid/ready streams of the controller.
// Ports: patch_valid/patch_ready/patch_data (query), leaf_valid/leaf_ready/leaf_index (result).
//   slave  = controller view, master = upstream/downstream view.
interface kd_tree_controller_if #(
  parameter int PATCH_WIDTH   = kd_ctrl_pkg::PATCH_WIDTH,
  parameter int ADDRESS_WIDTH = kd_ctrl_pkg::ADDRESS_WIDTH
);
  logic                     patch_valid;
  logic                     patch_ready;
  logic [PATCH_WIDTH-1:0]   patch_data;
  logic                     leaf_valid;
  logic                     leaf_ready;
  logic [ADDRESS_WIDTH-1:0] leaf_index;

  modport slave (
    input  patch_valid, patch_data, leaf_ready,
    output patch_ready, leaf_valid, leaf_index
  );

  modport master (
    output patch_valid, patch_data, leaf_ready,
    input  patch_ready, leaf_valid, leaf_index
  );
endinterface

// File: rtl/kd_tree_controller_leaf_result_fifo.sv
// rtl/kd_tree_controller_leaf_result_fifo.sv - show-ahead result FIFO with occupancy count
// Purpose: synchronous FIFO; head word visible on o_data while non-empty, zero when empty.
// Ports: i_clk, i_rst (sync, active-high), i_push/i_data, i_pop, o_data, o_empty, o_count.
module leaf_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW  = $clog2(DEPTH),
  localparam int CW  = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);
  import kd_ctrl_pkg::*;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_rd_ptr;
  logic             w_empty;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !w_empty;
  // A pop in the same cycle frees the slot, so push-at-full is accepted then.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + CW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = w_empty;
  assign o_count = r_wr_ptr - r_rd_ptr;
endmodule

// File: rtl/kd_tree_controller.sv
// rtl/kd_tree_controller.sv - LOAD/SEARCH sequencer for the internal-node tree
// Purpose: counts node words during LOAD, then issues query patches into the fixed-latency
//   tree and returns leaf indices in issue order through a credit-limited FIFO.
// Ports: i_clk, i_rst (sync, active-high), i_start, i_node_enq, o_node_full_n,
//   o_tree_fsm_enable, o_load_done, o_tree_patch_in, i_tree_leaf_index, o_node_count,
//   io_bus (patch/leaf handshakes, slave modport).
module kd_tree_controller #(
  parameter int NUM_NODES     = kd_ctrl_pkg::NUM_NODES,
  parameter int PATCH_WIDTH   = kd_ctrl_pkg::PATCH_WIDTH,
  parameter int ADDRESS_WIDTH = kd_ctrl_pkg::ADDRESS_WIDTH,
  parameter int TREE_LATENCY  = 6,
  parameter int OUT_DEPTH     = 4,
  localparam int NC_W         = $clog2(NUM_NODES + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_node_enq,
  output logic                     o_node_full_n,
  output logic                     o_tree_fsm_enable,
  output logic                     o_load_done,
  output logic [PATCH_WIDTH-1:0]   o_tree_patch_in,
  input  logic [ADDRESS_WIDTH-1:0] i_tree_leaf_index,
  output logic [NC_W-1:0]          o_node_count,
  kd_tree_controller_if.slave      io_bus
);
  import kd_ctrl_pkg::*;

  localparam int FC_W = $clog2(OUT_DEPTH) + 1;
  localparam int IF_W = $clog2(TREE_LATENCY + 1);
  localparam int CR_W = $clog2(TREE_LATENCY + OUT_DEPTH + 1);

  state_t                   r_state;
  state_t                   w_state_next;
  logic [NC_W-1:0]          r_node_count;
  logic                     r_reload_pending;
  logic [TREE_LATENCY-1:0]  r_valid_pipe;
  logic [IF_W-1:0]          r_inflight;
  logic [PATCH_WIDTH-1:0]   r_tree_patch;
  logic                     w_issue;
  logic                     w_capture;
  logic                     w_pop;
  logic                     w_last_node;
  logic                     w_reload_req;
  logic                     w_drained;
  logic                     w_credit_ok;
  logic                     w_fifo_empty;
  logic [FC_W-1:0]          w_fifo_count;
  logic [ADDRESS_WIDTH-1:0] w_fifo_head;

  // A start in the same cycle restarts the load, so it overrides the final enq.
  assign w_last_node  = (r_state == ST_LOAD) && i_node_enq && !i_start &&
                        (r_node_count == NC_W'(NUM_NODES - 1));
  // Start counts as a pending reload immediately so no patch slips in as we leave SEARCH.
  assign w_reload_req = r_reload_pending || i_start;
  assign w_drained    = (r_inflight == '0) && w_fifo_empty;
  // Every in-flight patch owns a FIFO slot, so capture can never overflow the FIFO.
  assign w_credit_ok  = (CR_W'(r_inflight) + CR_W'(w_fifo_count)) < CR_W'(OUT_DEPTH);
  assign w_issue      = io_bus.patch_valid && io_bus.patch_ready;
  assign w_capture    = r_valid_pipe[TREE_LATENCY-1];
  assign w_pop        = io_bus.leaf_valid && io_bus.leaf_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (i_start) w_state_next = ST_LOAD;
      ST_LOAD:   if (w_last_node) w_state_next = ST_SEARCH;
      ST_SEARCH: if (w_reload_req && w_drained) w_state_next = ST_LOAD;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_node_full_n      = 1'b0;
    o_tree_fsm_enable  = 1'b0;
    o_load_done        = 1'b0;
    io_bus.patch_ready = 1'b0;
    case (r_state)
      ST_LOAD: begin
        o_node_full_n     = 1'b1;
        o_tree_fsm_enable = 1'b1;
      end
      ST_SEARCH: begin
        o_load_done        = 1'b1;
        io_bus.patch_ready = !w_reload_req && w_credit_ok;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_node_count     <= '0;
      r_reload_pending <= 1'b0;
      r_valid_pipe     <= '0;
      r_inflight       <= '0;
      r_tree_patch     <= '0;
    end else begin
      if ((r_state != ST_LOAD && w_state_next == ST_LOAD) || (r_state == ST_LOAD && i_start))
        r_node_count <= '0;
      else if (r_state == ST_LOAD && i_node_enq)
        r_node_count <= r_node_count + NC_W'(1);

      if (r_state == ST_SEARCH && w_state_next == ST_LOAD) r_reload_pending <= 1'b0;
      else if (r_state == ST_SEARCH && i_start)           r_reload_pending <= 1'b1;

      // Valid tokens march alongside the tree pipeline; the last stage marks a ready result.
      r_valid_pipe <= (r_valid_pipe << 1) | TREE_LATENCY'(w_issue);

      case ({w_issue, w_capture})
        2'b10:   r_inflight <= r_inflight + IF_W'(1);
        2'b01:   r_inflight <= r_inflight - IF_W'(1);
        default: r_inflight <= r_inflight;
      endcase

      if (w_issue) r_tree_patch <= io_bus.patch_data;
    end
  end

  leaf_result_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (ADDRESS_WIDTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_capture),
    .i_data  (i_tree_leaf_index),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign io_bus.leaf_valid = !w_fifo_empty;
  assign io_bus.leaf_index = w_fifo_head;
  assign o_tree_patch_in   = r_tree_patch;
  assign o_node_count      = r_node_count;
endmodule

// File: doc/kd_tree_controller.md
Name: kd_tree_controller

Overview:
- Sequences the internal_node_tree through two phases: LOAD, then SEARCH.
- LOAD: gates the aggregator-to-tree node stream, counts the exact number of internal-node words and asserts the tree's fsm_enable only while loading.
- SEARCH: issues query patches into the fixed-latency tree with a valid/ready handshake, then returns leaf indices in order through a credit-limited output FIFO, so downstream backpressure never drops a result.
- Sits between the input fetch path (async_fifo1 → aggregator) and the leaf-processing stage.

Parameters:
NUM_NODES, 63, number of aggregated internal-node words per tree load
PATCH_WIDTH, 55, query patch width (5 x 11-bit signed)
ADDRESS_WIDTH, 8, leaf index width
TREE_LATENCY, 6, cycles from tree patch_in to valid leaf_index (>=1)
OUT_DEPTH, 4, output FIFO depth, power of two, >=2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a new tree load
node_enq  in  1  aggregator receiver_enq (one node word this cycle)
node_full_n  out  1  to aggregator receiver_full_n; high only in LOAD
tree_fsm_enable  out  1  to internal_node_tree fsm_enable
load_done  out  1  high while in SEARCH
patch_valid  in  1  query patch offered
patch_ready  out  1  controller accepts patch this cycle
patch_data  in  PATCH_WIDTH  query patch
tree_patch_in  out  PATCH_WIDTH  registered patch to tree
tree_leaf_index  in  ADDRESS_WIDTH  tree result
leaf_valid  out  1  result available
leaf_ready  in  1  downstream accepts result
leaf_index  out  ADDRESS_WIDTH  result, issue order
node_count  out  clog2(NUM_NODES+1)  node words received this load

Behaviour:
- Reset, synchronous on the clk edge with rst=1:
  - state=IDLE; all outputs 0, including tree_patch_in, node_count and leaf_index.
  - In-flight pipeline valid bits cleared; FIFO emptied.
  - Reset mid-load or mid-search abandons all work: in-flight results are discarded and are never emitted.
- States:
  - IDLE: start → LOAD; clear node_count.
  - LOAD:
    - node_full_n=1 and tree_fsm_enable=1.
    - Each cycle with node_enq, node_count increments.
    - On the cycle node_count reaches NUM_NODES (the last enq), the next state is SEARCH.
    - From the cycle after, node_full_n=0 and tree_fsm_enable=0, so the tree stops overwriting.
    - node_enq while node_full_n=0 is ignored and does not count.
  - SEARCH:
    - load_done=1.
    - start → LOAD (reload), but only once inflight==0 and the FIFO is empty. Until then start is held pending and patch_ready=0.
- Issue rule:
  - patch_ready = (state==SEARCH) && !reload_pending && (inflight + fifo_count < OUT_DEPTH).
  - On patch_valid && patch_ready: tree_patch_in <= patch_data, and a 1 is shifted into a TREE_LATENCY-deep valid pipeline.
  - tree_patch_in holds its last value when idle.
  - Throughput: 1 patch/cycle when credits are available.
- Capture: when the pipeline's last stage is valid, tree_leaf_index is pushed into the FIFO in the same cycle.
  - Credits guarantee no overflow. Asserting a push while full is a design error; the bench checks it.
- Output: leaf_valid = FIFO non-empty; leaf_index = FIFO head (show-ahead); pop on leaf_valid && leaf_ready.
  - Simultaneous push and pop is allowed at full or empty. When the FIFO is empty, a push appears on leaf_valid the next cycle.
  - Total latency from accept to leaf_valid is TREE_LATENCY+1 cycles.
- Counters: inflight = popcount of the pipeline, maintained as an up/down counter (+issue, −capture, both → unchanged). FIFO pointers wrap modulo OUT_DEPTH using an extra MSB for full/empty.
- start asserted in LOAD restarts the load: node_count=0 and the state stays LOAD.

Decomposition:
- Shared package kd_ctrl_pkg holds:
  - the state enum typedef (IDLE, LOAD, SEARCH);
  - the default widths PATCH_WIDTH=55, ADDRESS_WIDTH=8, DSIZE=11;
  - NUM_NODES=63.
- One sub-module, leaf_result_fifo: synchronous show-ahead FIFO (depth OUT_DEPTH, width ADDRESS_WIDTH) with count output.

Test Plan:
- Load count: start, then 63 node_enq pulses with random gaps (stall ~50%) → tree_fsm_enable high for exactly the load window; load_done rises 1 cycle after the 63rd enq; node_count=63; a 64th enq is ignored.
- Single search (tree loaded from internalNodes.txt):
  - patch [251,-26,-1,-88,79] (55'b0001111101111111100110111111111111111010100000001001111) → leaf_index=63, leaf_valid 7 cycles after accept.
  - patch [-72,-213,201,45,235] → leaf_index=5.
- Back-to-back issue with leaf_ready=1, patches for 63,63,5 on consecutive cycles → results 63,63,5 in order on consecutive cycles.
- Backpressure: leaf_ready=0, patch_valid held high → exactly 4 patches accepted and patch_ready then stays 0. Releasing leaf_ready → 4 results in order, then issue resumes.
- Reload: start in SEARCH with 2 results pending → patch_ready=0 until both are popped, then LOAD and node_count=0.
- Reset mid-search with 3 in flight → next cycle leaf_valid=0 and patch_ready=0, and no stale result appears afterward.
